// File: rtl/ofmap_pack_writer.sv
// Output-feature-map writer: buffers LANES-wide fp16 groups, packs two lanes per 32-bit SRAM word.
// Optional OFMAP_WR_SAT_EN clamps Inf/NaN elements to +/- max finite fp16 before packing.
module ofmap_pack_writer #(
    parameter int LANES       = 4,
    parameter int DW          = 16,
    parameter int AW          = 13,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 240,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    output logic                sram_we,
    output logic [AW-1:0]       sram_addr,
    output logic [31:0]         sram_wdata,
    output logic                busy,
    output logic                frame_done,
    output logic [AW-1:0]       word_cnt
);

    localparam int WPG    = LANES / 2;
    localparam int GROUPS = FRAME_WORDS / WPG;
    localparam int GW     = LANES * DW;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int IW     = (WPG > 1) ? $clog2(WPG) : 1;
    localparam int CW     = $clog2(GROUPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [AW-1:0]   word_cnt_q, word_cnt_d;
    logic [CW-1:0]   grp_cnt_q, grp_cnt_d;
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   cur_grp_q, cur_grp_d;
    logic [IW-1:0]   widx_q, widx_d;

    logic [GW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [GW-1:0]   head;
    logic            fifo_empty, fifo_full, pop, push;

    function automatic logic [15:0] fix_elem(input logic [15:0] e);
`ifdef OFMAP_WR_SAT_EN
        if (e[14:10] == 5'h1F) return e[15] ? 16'hFBFF : 16'h7BFF;
        return e;
`else
        return e;
`endif
    endfunction

    function automatic logic [31:0] pack_word(input logic [31:0] w);
        return {fix_elem(w[31:16]), fix_elem(w[15:0])};
    endfunction

    assign head       = fifo_mem[rd_ptr_q[PW-1:0]];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // The writer pops only between groups, so a pop is known from flops alone and may free a full slot.
    assign pop        = (widx_q == '0) && !fifo_empty;
    assign in_ready   = (state_q == RUN) && (!fifo_full || pop) && (grp_cnt_q < CW'(GROUPS));
    assign push       = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_cnt_d = word_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cur_grp_d  = cur_grp_q;
        widx_d     = widx_q;

        if (we_q) begin
            addr_d     = addr_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
        end

        if (widx_q != '0) begin
            we_d    = 1'b1;
            wdata_d = pack_word(cur_grp_q[int'(widx_q)*32 +: 32]);
            widx_d  = (widx_q == IW'(WPG - 1)) ? '0 : widx_q + 1'b1;
        end else if (pop) begin
            we_d      = 1'b1;
            wdata_d   = pack_word(head[31:0]);
            cur_grp_d = head;
            widx_d    = (WPG > 1) ? IW'(1) : '0;
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end

        if (push) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            grp_cnt_d = grp_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    word_cnt_d = '0;
                    grp_cnt_d  = '0;
                    addr_d     = AW'(BASE_ADDR);
                end
            end
            RUN: begin
                if (push && grp_cnt_q == CW'(GROUPS - 1)) state_d = FLUSH;
            end
            FLUSH: begin
                // word_cnt lags the write by one edge, so this fires the cycle after the final strobe.
                if (we_q && word_cnt_q == AW'(FRAME_WORDS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= AW'(BASE_ADDR);
            wdata_q    <= '0;
            word_cnt_q <= '0;
            grp_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cur_grp_q  <= '0;
            widx_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_cnt_q <= word_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cur_grp_q  <= cur_grp_d;
            widx_q     <= widx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= in_data;
    end

    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign word_cnt   = word_cnt_q;

endmodule
